// File: rtl/clic_trig_gateway.sv
// Per-source CLIC interrupt gateway: level/edge trigger modes, edge-pending state, lost-edge flags.
// Define CLIC_IRQ_SYNC_EN to put a 2-flop synchroniser in front of each raw interrupt line.
module clic_trig_gateway #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned SRC_W    = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SOURCE-1:0]      irq_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      ie_i,
  input  logic [N_SOURCE-1:0]      ip_we_i,
  input  logic [N_SOURCE-1:0]      ip_wdata_i,
  input  logic                     claim_valid_i,
  input  logic [SRC_W-1:0]         claim_id_i,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic [N_SOURCE-1:0]      active_o,
  output logic [N_SOURCE-1:0]      ovf_o
);

  logic [N_SOURCE-1:0] irq_s;
  logic [N_SOURCE-1:0] lvl;
  logic [N_SOURCE-1:0] edge_det;
  logic [N_SOURCE-1:0] claim_hit;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] ip_q, ip_d;
  logic [N_SOURCE-1:0] ovf_q, ovf_d;

`ifdef CLIC_IRQ_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // IDs at or above N_SOURCE never match any loop index, so they are ignored.
  always_comb begin
    lvl       = '0;
    claim_hit = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      lvl[i]       = irq_s[i] ^ trig_i[i][1];
      claim_hit[i] = claim_valid_i && (claim_id_i == SRC_W'(i));
    end
  end

  // prev_q tracks in every mode so a level->edge switch raises no spurious edge.
  assign edge_det = lvl & ~prev_q;

  always_comb begin
    ip_d  = ip_q;
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      if (!trig_i[i][0]) begin
        ip_d[i] = lvl[i];
      end else if (ip_we_i[i]) begin
        ip_d[i]  = ip_wdata_i[i];
        ovf_d[i] = 1'b0;
      end else if (edge_det[i]) begin
        ip_d[i] = 1'b1;
        if (ip_q[i] && !claim_hit[i]) begin
          ovf_d[i] = 1'b1;
        end
      end else if (claim_hit[i]) begin
        ip_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      ip_q   <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= lvl;
      ip_q   <= ip_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ip_o     = ip_q;
  assign active_o = ip_q & ie_i;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_clic_trig_gateway.sv
// Directed bench for clic_trig_gateway (default build): vector table plus reset/mode-change sequences.
module tb_clic_trig_gateway;

  localparam logic [31:0] All = 32'hFFFF_FFFF;

  logic             clk;
  logic             rst_n;
  logic [31:0]      irq;
  logic [31:0][1:0] trig;
  logic [31:0]      ie;
  logic [31:0]      ip_we;
  logic [31:0]      ip_wdata;
  logic             claim_valid;
  logic [5:0]       claim_id;
  logic [31:0]      ip;
  logic [31:0]      active;
  logic [31:0]      ovf;

  int checks = 0;
  int errors = 0;

  clic_trig_gateway #(
    .N_SOURCE(32),
    .SRC_W   (6)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .irq_i        (irq),
    .trig_i       (trig),
    .ie_i         (ie),
    .ip_we_i      (ip_we),
    .ip_wdata_i   (ip_wdata),
    .claim_valid_i(claim_valid),
    .claim_id_i   (claim_id),
    .ip_o         (ip),
    .active_o     (active),
    .ovf_o        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] irq;
    logic [31:0] ie;
    logic [31:0] we;
    logic [31:0] wd;
    logic        cv;
    logic [5:0]  cid;
    logic [31:0] eip;
    logic [31:0] eovf;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [31:0] i_irq, input logic [31:0] i_ie,
                     input logic [31:0] i_we, input logic [31:0] i_wd, input logic i_cv,
                     input logic [5:0] i_cid, input logic [31:0] e_ip, input logic [31:0] e_ovf);
    vec_t v;
    v = '{name, i_irq, i_ie, i_we, i_wd, i_cv, i_cid, e_ip, e_ovf};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    ip_we       = '0;
    ip_wdata    = '0;
    claim_valid = 1'b0;
    claim_id    = '0;
  endtask

  initial begin
    // src0 negative level; everything else positive edge
    for (int i = 0; i < 32; i++) trig[i] = 2'b01;
    trig[0] = 2'b10;

    //  name            irq       ie          we       wd       cv cid  exp ip   exp ovf
    add("idle",         32'h1,    All,        '0,      '0,      0, 0,  32'h0,   32'h0);
    add("edge3",        32'h9,    All,        '0,      '0,      0, 0,  32'h8,   32'h0);
    add("hold3",        32'h1,    All,        '0,      '0,      0, 0,  32'h8,   32'h0);
    add("claim3",       32'h1,    All,        '0,      '0,      1, 3,  32'h0,   32'h0);
    add("nlvl_low0",    32'h0,    All,        '0,      '0,      0, 0,  32'h1,   32'h0);
    add("nlvl_claim0",  32'h0,    All,        '0,      '0,      1, 0,  32'h1,   32'h0);
    add("nlvl_we0",     32'h0,    All,        32'h1,   '0,      0, 0,  32'h1,   32'h0);
    add("nlvl_high0",   32'h1,    All,        '0,      '0,      0, 0,  32'h0,   32'h0);
    add("edge5",        32'h21,   All,        '0,      '0,      0, 0,  32'h20,  32'h0);
    add("low5",         32'h1,    All,        '0,      '0,      0, 0,  32'h20,  32'h0);
    add("edge_claim5",  32'h21,   All,        '0,      '0,      1, 5,  32'h20,  32'h0);
    add("low5b",        32'h1,    All,        '0,      '0,      0, 0,  32'h20,  32'h0);
    add("edge5_ovf",    32'h21,   All,        '0,      '0,      0, 0,  32'h20,  32'h20);
    add("claim5_stick", 32'h1,    All,        '0,      '0,      1, 5,  32'h0,   32'h20);
    add("sw_clr5",      32'h21,   All,        32'h20,  '0,      0, 0,  32'h0,   32'h0);
    add("low5c",        32'h1,    All,        '0,      '0,      0, 0,  32'h0,   32'h0);
    add("we_edge5",     32'h21,   All,        32'h20,  '0,      0, 0,  32'h0,   32'h0);
    add("ie7_off",      32'h81,   ~32'h80,    '0,      '0,      0, 0,  32'h80,  32'h0);
    add("ie7_on",       32'h81,   All,        '0,      '0,      0, 0,  32'h80,  32'h0);
    add("claim_oob",    32'h81,   All,        '0,      '0,      1, 39, 32'h80,  32'h0);
    add("claim7",       32'h81,   All,        '0,      '0,      1, 7,  32'h0,   32'h0);
    add("sw_set12",     32'h81,   All,        32'h1000,32'h1000,0, 0,  32'h1000,32'h0);
    add("we_claim12",   32'h81,   All,        32'h1000,32'h1000,1, 12, 32'h1000,32'h0);
    add("claim12",      32'h81,   All,        '0,      '0,      1, 12, 32'h0,   32'h0);
    add("release",      32'h1,    All,        '0,      '0,      0, 0,  32'h0,   32'h0);

    // Reset state
    rst_n = 1'b0;
    irq   = 32'h1;
    ie    = All;
    idle_inputs();
    #12;
    chk("rst_ip", ip, 32'h0);
    chk("rst_active", active, 32'h0);
    chk("rst_ovf", ovf, 32'h0);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      irq         = vq[k].irq;
      ie          = vq[k].ie;
      ip_we       = vq[k].we;
      ip_wdata    = vq[k].wd;
      claim_valid = vq[k].cv;
      claim_id    = vq[k].cid;
      step();
      chk({vq[k].name, "_ip"}, ip, vq[k].eip);
      chk({vq[k].name, "_ovf"}, ovf, vq[k].eovf);
      chk({vq[k].name, "_active"}, active, vq[k].eip & vq[k].ie);
    end
    idle_inputs();

    // active_o follows ie_i without a clock
    irq = 32'h401;
    ie  = ~32'h400;
    step();
    chk("ie10_masked_ip", ip, 32'h400);
    chk("ie10_masked_active", active, 32'h0);
    ie = All;
    #1;
    chk("ie10_comb_active", active, 32'h400);

    // Level -> edge with constant polarity: no spurious edge
    trig[9] = 2'b00;
    irq     = 32'h601;
    step();
    chk("lvl9_ip", ip, 32'h600);
    trig[9] = 2'b01;
    step();
    chk("lvl2edge9_ip", ip, 32'h600);
    claim_valid = 1'b1;
    claim_id    = 6'd9;
    step();
    chk("claim9_ip", ip, 32'h400);
    idle_inputs();
    step();
    chk("no_spurious9_ip", ip, 32'h400);
    chk("no_spurious9_ovf", ovf, 32'h0);

    // Fill everything, create an overflow, then reset mid-operation
    for (int i = 0; i < 32; i++) trig[i] = 2'b01;
    irq      = 32'h0;
    ip_we    = All;
    ip_wdata = All;
    step();
    chk("fill_ip", ip, All);
    idle_inputs();
    irq = 32'h2;
    step();
    chk("ovf1_ovf", ovf, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ip", ip, 32'h0);
    chk("midrst_active", active, 32'h0);
    chk("midrst_ovf", ovf, 32'h0);
    step();
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_pre_clk_ip", ip, 32'h0);
    step();
    chk("rel_first_edge_ip", ip, 32'h2);
    chk("rel_first_edge_ovf", ovf, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clic_trig_gateway.md
# clic_trig_gateway

Per-source interrupt gateway that sits between the raw interrupt lines and the CLIC register file and arbiter. It implements all four CLIC trigger modes (positive/negative level, positive/negative edge) and holds edge-pending state until the core claims the source or software writes it. It reports a sticky lost-edge flag per source. It is the parametrised successor of the fixed positive-trigger adapter and drives the `ip` hardware-write path and the arbiter's pending vector.

## Interface
- `N_SOURCE`, default 32: number of interrupt sources.
- `SRC_W`, default `$clog2(N_SOURCE)`: width of the claim ID.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `irq_i` in, `N_SOURCE`: raw interrupt lines.
- `trig_i` in, `N_SOURCE`x2: per-source `attr.trig`.
  - `[0]`: 1 = edge, 0 = level.
  - `[1]`: 1 = active-low / falling, 0 = active-high / rising.
- `ie_i` in, `N_SOURCE`: per-source enable.
- `ip_we_i` in, `N_SOURCE`: software write strobe to `clicintip`.
- `ip_wdata_i` in, `N_SOURCE`: software write value.
- `claim_valid_i` in, 1: core accepted an interrupt this cycle.
- `claim_id_i` in, `SRC_W`: ID of the claimed source.
- `ip_o` out, `N_SOURCE`: pending state, fed to register readback and the arbiter.
- `active_o` out, `N_SOURCE`: `ip_o & ie_i`, combinational.
- `ovf_o` out, `N_SOURCE`: sticky lost-edge flag.

## Operation
- Per-source normalised level: `lvl = irq_s ^ trig_i[1]`.
  - `irq_s` is `irq_i`, or its synchronised version when the synchroniser is enabled (see Configuration).
- `prev_q` register holds the previous `lvl`. It updates every cycle, in every mode.
- Edge detect: `edge = lvl & ~prev_q`.
- Level mode (`trig_i[0]=0`):
  - `ip_q <= lvl` every cycle.
  - `ip_we_i` and claim are ignored.
  - `ovf_q` holds its value.
- Edge mode (`trig_i[0]=1`), priority from highest to lowest:
  1. `ip_we_i[i]` loads `ip_q <= ip_wdata_i[i]` and clears `ovf_q`.
  2. `edge` sets `ip_q`.
  3. A claim with `claim_valid_i & claim_id_i==i` clears `ip_q`.
  - Otherwise `ip_q` holds.
- Simultaneous edge and claim on the same source: `ip_q` stays 1, so the new edge is not lost. `ovf_q` is not set.
- Overflow: `edge & ip_q & ~claim_hit & ~ip_we` sets `ovf_q[i]`. Only a software write clears it.
- `claim_id_i >= N_SOURCE` is ignored.
- `ie_i` gates only `active_o`. Pending state accumulates regardless of `ie_i`.
- Mode change:
  - Level to edge with constant polarity raises no spurious edge, because `prev_q` is always tracking.
  - Toggling `trig_i[1]` can produce one edge. Software masks `ie_i` before a polarity change.

## Timing
- Reset: `ip_q`, `prev_q`, `ovf_q` and the synchroniser flops are 0, so `ip_o`, `active_o` and `ovf_o` are 0.
- First cycle after reset: an active `lvl` counts as an edge, because `prev_q` is 0.
- Latency from `irq_i` change to `ip_o`: 1 cycle without the synchroniser, 3 cycles with it.
- Software write and claim take effect on `ip_o` 1 cycle after the strobe.
- A reset asserted mid-operation clears all state asynchronously. Pending edges are lost.

## Configuration
- `CLIC_IRQ_SYNC_EN` defined:
  - A 2-flop synchroniser per source sits in front of the edge and level logic.
  - The synchroniser flops reset to 0.
  - It adds 2 cycles of latency.
- `CLIC_IRQ_SYNC_EN` undefined:
  - `irq_s = irq_i`.
  - Sources must already be synchronous to `clk_i`.

## Test plan
- Positive edge, src 3: pulse `irq_i[3]` for 1 cycle at cycle 10 → `ip_o[3]=1` at cycle 11 (13 with sync). Claim id 3 at cycle 20 → `ip_o[3]=0` at cycle 21.
- Negative level, src 0, `trig=2'b10`: drive `irq_i[0]=0` → `ip_o[0]=1` one cycle later. Drive it to 1 → `ip_o[0]=0`. Claims have no effect.
- Edge plus claim in the same cycle on src 5 → `ip_o[5]` stays 1 and `ovf_o[5]=0`. A second edge with no claim → `ovf_o[5]=1`. A software write of 0 → `ip_o[5]=0` and `ovf_o[5]=0`.
- Software write and edge in the same cycle, wdata 0, edge mode → `ip_o=0` next cycle (software wins).
- `ie_i[7]=0` with an edge on src 7 → `ip_o[7]=1` and `active_o[7]=0`. Set `ie_i[7]=1` → `active_o[7]=1` in the same cycle.
- Reset asserted while `ip_o` is 0xFFFF_FFFF → all outputs 0 immediately. Release with `irq_i[1]=1`, positive edge mode → `ip_o[1]=1` one cycle after the first clock.
